// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
//   Write-side controller of an asynchronous FIFO. Keeps the binary write
//   pointer, publishes it in Gray code to the read domain, synchronizes the
//   read-domain Gray pointer and derives full / almost-full / fill level and a
//   sticky overflow flag from it. Every status output is registered. wclk_en
//   is the only combinational output.
//
// Parameters
//   DEPTH      FIFO entries (power of two, >= 4)
//   AFULL_LVL  fill level at or above which walmost_full asserts (1..DEPTH)
//   A          address width, derived from DEPTH
//
// Ports
//   WCLK          write-domain clock (rising edge)
//   WRST          asynchronous active-high reset
//   winc          write request from the producer
//   rptr_gray     read pointer in Gray code (read clock domain)
//   wovf_clr      clears the sticky overflow flag
//   waddr         write address to the FIFO memory
//   wclk_en       write strobe to the FIFO memory (winc & ~wfull)
//   wptr_gray     registered Gray write pointer to the read domain
//   wfull         FIFO full
//   walmost_full  fill level >= AFULL_LVL
//   wlevel        conservative fill level, 0..DEPTH
//   woverflow     sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module fifo_wr_ctrl #(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 14,
  parameter int A         = $clog2(DEPTH)
) (
  input  logic         WCLK,
  input  logic         WRST,
  input  logic         winc,
  input  logic [A:0]   rptr_gray,
  input  logic         wovf_clr,
  output logic [A-1:0] waddr,
  output logic         wclk_en,
  output logic [A:0]   wptr_gray,
  output logic         wfull,
  output logic         walmost_full,
  output logic [A:0]   wlevel,
  output logic         woverflow
);

  localparam logic [A:0] DEPTH_V = (A+1)'(DEPTH);
  localparam logic [A:0] AFULL_V = (A+1)'(AFULL_LVL);

  logic [A:0] rq1;
  logic [A:0] rq2;
  logic [A:0] wbin;

  logic [A:0] wbin_next;
  logic [A:0] wgray_next;
  logic [A:0] rbin_s;
  logic [A:0] level_raw;
  logic [A:0] level_next;
  logic       full_next;
  logic       afull_next;
  logic       ovf_next;

  assign wclk_en = winc & ~wfull;
  assign waddr   = wbin[A-1:0];

  // NOTE: every signal assigned here gets a value on every path (defaults
  // first), so no latch can be inferred.
  always_comb begin
    wbin_next  = wbin + {{A{1'b0}}, wclk_en};
    wgray_next = wbin_next ^ (wbin_next >> 1);

    // Gray-to-binary: bit i is the XOR of all Gray bits at and above i.
    rbin_s = '0;
    for (int i = 0; i <= A; i++) begin
      rbin_s[i] = ^(rq2 >> i);
    end

    // Full when the next write pointer has lapped the synchronized read
    // pointer exactly once: top two Gray bits inverted, the rest equal.
    full_next = (wgray_next == {~rq2[A:A-1], rq2[A-2:0]});

    // rq2 lags the true read pointer, so this difference can only overstate
    // the fill level. Saturation guards against a corrupted pointer ever
    // reporting more than DEPTH.
    level_raw  = wbin_next - rbin_s;
    level_next = (level_raw > DEPTH_V) ? DEPTH_V : level_raw;
    afull_next = (level_next >= AFULL_V);

    // A new overflow wins over a simultaneous clear.
    ovf_next = (winc & wfull) | (woverflow & ~wovf_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the two-flop synchronizer depends on this.
  always_ff @(posedge WCLK or posedge WRST) begin
    if (WRST) begin
      rq1          <= '0;
      rq2          <= '0;
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      rq1          <= rptr_gray;
      rq2          <= rq1;
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wlevel       <= level_next;
      woverflow    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
//   Directed bench for fifo_wr_ctrl (DEPTH=16, AFULL_LVL=14). The stimulus
//   process drives one vector per clock on the falling edge and queues the
//   hand-computed response; a monitor process samples wclk_en before the
//   rising edge and the registered outputs just after it, then pops and
//   compares. Asynchronous reset behaviour is checked directly.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

  logic       WCLK;
  logic       WRST;
  logic       winc;
  logic [4:0] rptr_gray;
  logic       wovf_clr;
  logic [3:0] waddr;
  logic       wclk_en;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  typedef struct {
    logic       en;
    logic [3:0] waddr;
    logic [4:0] wgray;
    logic       full;
    logic       afull;
    logic [4:0] level;
    logic       ovf;
    logic       onebit;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  fifo_wr_ctrl #(.DEPTH(16), .AFULL_LVL(14)) dut (
    .WCLK         (WCLK),
    .WRST         (WRST),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wclk_en      (wclk_en),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  initial WCLK = 1'b0;
  always #5 WCLK = ~WCLK;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the expected state after the following edge.
  task automatic step(input logic inc, input logic [4:0] rp, input logic clr,
                      input logic e_en, input logic [4:0] e_wbin, input logic e_full,
                      input logic [4:0] e_level, input logic e_ovf, input logic onebit);
    exp_t r;
    @(negedge WCLK);
    winc      = inc;
    rptr_gray = rp;
    wovf_clr  = clr;
    r.en     = e_en;
    r.waddr  = e_wbin[3:0];
    r.wgray  = gray(e_wbin);
    r.full   = e_full;
    r.afull  = (e_level >= 5'd14);
    r.level  = e_level;
    r.ovf    = e_ovf;
    r.onebit = onebit;
    sb.push_back(r);
  endtask

  // Asserts reset between edges with winc=1, checks outputs asynchronously,
  // then releases with all inputs idle.
  task automatic do_reset();
    @(negedge WCLK);
    winc      = 1'b1;
    rptr_gray = 5'd0;
    wovf_clr  = 1'b0;
    #2 WRST = 1'b1;
    #1;
    check("rst_waddr",  32'(waddr),        32'd0);
    check("rst_wgray",  32'(wptr_gray),    32'd0);
    check("rst_wfull",  32'(wfull),        32'd0);
    check("rst_afull",  32'(walmost_full), 32'd0);
    check("rst_wlevel", 32'(wlevel),       32'd0);
    check("rst_ovf",    32'(woverflow),    32'd0);
    check("rst_en_hi",  32'(wclk_en),      32'd1);
    winc = 1'b0;
    #1;
    check("rst_en_lo",  32'(wclk_en),      32'd0);
    @(negedge WCLK);
    WRST = 1'b0;
    #1;
    check("rel_waddr",  32'(waddr),        32'd0);
  endtask

  // Monitor: pops one expectation per clock in which one was queued.
  initial begin : monitor
    exp_t       rec;
    logic       en_s;
    logic [4:0] prev_gray;
    prev_gray = 5'd0;
    forever begin
      @(negedge WCLK);
      #2 en_s = wclk_en;
      @(posedge WCLK);
      #1;
      if (sb.size() > 0) begin
        rec = sb.pop_front();
        check("wclk_en",      32'(en_s),         32'(rec.en));
        check("waddr",        32'(waddr),        32'(rec.waddr));
        check("wptr_gray",    32'(wptr_gray),    32'(rec.wgray));
        check("wfull",        32'(wfull),        32'(rec.full));
        check("walmost_full", 32'(walmost_full), 32'(rec.afull));
        check("wlevel",       32'(wlevel),       32'(rec.level));
        check("woverflow",    32'(woverflow),    32'(rec.ovf));
        if (rec.onebit)
          check("gray_onebit", 32'($countones(wptr_gray ^ prev_gray)), 32'd1);
      end
      prev_gray = wptr_gray;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    WRST      = 1'b1;
    winc      = 1'b0;
    rptr_gray = 5'd0;
    wovf_clr  = 1'b0;
    do_reset();

    // Fill from empty with the reader parked at 0.
    for (int k = 1; k <= 16; k++)
      step(1'b1, 5'd0, 1'b0, 1'b1, 5'(k), (k == 16), 5'(k), 1'b0, 1'b0);
    @(posedge WCLK);
    #1 check("gray_at_16", 32'(wptr_gray), 32'h18);

    // Writes while full are dropped and set the sticky overflow.
    repeat (3) step(1'b1, 5'd0, 1'b0, 1'b0, 5'd16, 1'b1, 5'd16, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 5'd16, 1'b0, 1'b0);
    // Simultaneous overflow and clear: overflow wins.
    step(1'b1, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 5'd16, 1'b1, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 5'd16, 1'b0, 1'b0);

    // Reader advances to 1: visible on the third edge after the change.
    step(1'b0, 5'b00001, 1'b0, 1'b0, 5'd16, 1'b1, 5'd16, 1'b0, 1'b0);
    step(1'b0, 5'b00001, 1'b0, 1'b0, 5'd16, 1'b1, 5'd16, 1'b0, 1'b0);
    step(1'b0, 5'b00001, 1'b0, 1'b0, 5'd16, 1'b0, 5'd15, 1'b0, 1'b0);
    step(1'b1, 5'b00001, 1'b0, 1'b1, 5'd17, 1'b1, 5'd16, 1'b0, 1'b0);

    // Level 14, then reader moves to 2 while one more write lands.
    do_reset();
    for (int k = 1; k <= 14; k++)
      step(1'b1, 5'd0, 1'b0, 1'b1, 5'(k), 1'b0, 5'(k), 1'b0, 1'b0);
    step(1'b1, 5'b00011, 1'b0, 1'b1, 5'd15, 1'b0, 5'd15, 1'b0, 1'b0);
    step(1'b0, 5'b00011, 1'b0, 1'b0, 5'd15, 1'b0, 5'd15, 1'b0, 1'b0);
    step(1'b0, 5'b00011, 1'b0, 1'b0, 5'd15, 1'b0, 5'd13, 1'b0, 1'b0);

    // Wrap: 40 writes, reader 8 behind. The level seen at edge k uses the
    // read pointer driven two vectors earlier, so it plateaus at 10.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      int rd;
      int rused;
      rd    = (k > 8)  ? k - 8  : 0;
      rused = (k > 10) ? k - 10 : 0;
      step(1'b1, gray(5'(rd)), 1'b0, 1'b1, 5'(k), 1'b0, 5'(k - rused), 1'b0, 1'b1);
    end
    step(1'b0, gray(5'd0), 1'b0, 1'b0, 5'd8, 1'b0, 5'd9, 1'b0, 1'b0);
    step(1'b0, gray(5'd0), 1'b0, 1'b0, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0);
    step(1'b0, gray(5'd0), 1'b0, 1'b0, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0);

    // Reset mid-burst at level 9, then writing resumes from address 0.
    do_reset();
    for (int k = 1; k <= 9; k++)
      step(1'b1, 5'd0, 1'b0, 1'b1, 5'(k), 1'b0, 5'(k), 1'b0, 1'b0);
    do_reset();
    for (int k = 1; k <= 3; k++)
      step(1'b1, 5'd0, 1'b0, 1'b1, 5'(k), 1'b0, 5'(k), 1'b0, 1'b0);

    @(negedge WCLK);
    winc = 1'b0;
    repeat (2) @(posedge WCLK);
    #2 check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
